// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART/ALU sequencer: state encoding and ALU opcodes.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_seq_pkg;

  // 3-bit state encoding for the sequencer FSM.
  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    EXEC    = ST_EXEC,
    WAIT_TX = ST_WAIT_TX
  } seq_state_t;

  // Opcodes understood by the external ALU (funct-field style encoding).
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/tick_timeout.sv
// Inter-byte timeout: counts baud ticks while enabled, flags expiry on the tick that reaches the limit.
// Latency: o_expired is combinational from the counter and i_enable; the counter wraps to 0 on expiry.
// Backpressure: none; i_clear has priority over counting.
// Ports: i_clk/i_reset (async active-low), i_clear, i_enable (tick qualified by state), o_expired.
module tick_timeout #(
  parameter int TIMEOUT_TICKS = 16384
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] cnt;

  // Expiry is raised on the tick that would bring the count to TIMEOUT_TICKS,
  // so the caller can let a same-cycle byte win over the timeout.
  assign o_expired = i_enable && (cnt == LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (i_clear || o_expired) begin
      cnt <= '0;
    end else if (i_enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Sequencer between UART RX and TX: gathers A, B, opcode, drives the ALU, sends the result.
// Latency: tx_start pulses one cycle after the opcode byte is accepted; all outputs registered.
// Backpressure: none upstream; bytes arriving in EXEC/WAIT_TX are dropped and flagged on o_overrun.
// Ports: i_s_tick baud tick, i_rx_done/i_rx_data from RX, i_tx_done from TX, i_alu_result from ALU;
//        o_alu_a/b/op to ALU, o_tx_data/o_tx_start to TX, o_busy, o_timeout and o_overrun status pulses.
module uart_alu_sequencer
  import uart_seq_pkg::*;
#(
  parameter int DBIT          = 8,
  parameter int OP_BITS       = 6,
  parameter int TIMEOUT_TICKS = 16384
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx_done,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_tx_done,
  input  logic [DBIT-1:0]    i_alu_result,
  output logic [DBIT-1:0]    o_alu_a,
  output logic [DBIT-1:0]    o_alu_b,
  output logic [OP_BITS-1:0] o_alu_op,
  output logic [DBIT-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  seq_state_t         state, state_n;
  logic [DBIT-1:0]    alu_a_n, alu_b_n, tx_data_n;
  logic [OP_BITS-1:0] alu_op_n;
  logic               tx_start_n, busy_n, timeout_n, overrun_n;
  logic               collecting, accept, expired;

  // The timeout only runs once a frame has started (between bytes).
  assign collecting = (state == WAIT_B) || (state == WAIT_OP);
  assign accept     = i_rx_done && ((state == WAIT_A) || collecting);

  tick_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_tick_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (accept || !collecting),
    .i_enable  (collecting && i_s_tick),
    .o_expired (expired)
  );

  always_comb begin
    state_n    = state;
    alu_a_n    = o_alu_a;
    alu_b_n    = o_alu_b;
    alu_op_n   = o_alu_op;
    tx_data_n  = o_tx_data;
    tx_start_n = 1'b0;
    timeout_n  = 1'b0;
    overrun_n  = 1'b0;
    case (state)
      WAIT_A: begin
        if (i_rx_done) begin
          alu_a_n = i_rx_data;
          state_n = WAIT_B;
        end
      end
      WAIT_B: begin
        // A byte on the expiry tick wins: the frame continues.
        if (i_rx_done) begin
          alu_b_n = i_rx_data;
          state_n = WAIT_OP;
        end else if (expired) begin
          timeout_n = 1'b1;
          state_n   = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          alu_op_n = i_rx_data[OP_BITS-1:0];
          state_n  = EXEC;
        end else if (expired) begin
          timeout_n = 1'b1;
          state_n   = WAIT_A;
        end
      end
      EXEC: begin
        // o_alu_op settled last edge, so the ALU result is valid now.
        tx_data_n  = i_alu_result;
        tx_start_n = 1'b1;
        overrun_n  = i_rx_done;
        state_n    = WAIT_TX;
      end
      WAIT_TX: begin
        overrun_n = i_rx_done;
        if (i_tx_done) begin
          state_n = WAIT_A;
        end
      end
      default: state_n = WAIT_A;
    endcase
    busy_n = (state_n == EXEC) || (state_n == WAIT_TX);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      o_alu_a    <= alu_a_n;
      o_alu_b    <= alu_b_n;
      o_alu_op   <= alu_op_n;
      o_tx_data  <= tx_data_n;
      o_tx_start <= tx_start_n;
      o_busy     <= busy_n;
      o_timeout  <= timeout_n;
      o_overrun  <= overrun_n;
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Testbench for uart_alu_sequencer: directed scenarios plus randomized traffic against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_alu_sequencer;
  import uart_seq_pkg::*;

  localparam int DBIT    = 8;
  localparam int OP_BITS = 6;
  localparam int TT      = 8;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_s_tick;
  logic         i_rx_done;
  logic [7:0]   i_rx_data;
  logic         i_tx_done;
  logic [7:0]   i_alu_result;
  logic [7:0]   o_alu_a, o_alu_b, o_tx_data;
  logic [5:0]   o_alu_op;
  logic         o_tx_start, o_busy, o_timeout, o_overrun;
  logic [33:0]  got_vec;

  int checks = 0;
  int errors = 0;

  // Frame-level reference model state.
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  bit         m_start, m_busy, m_to, m_ov, m_exec;
  int         m_n, m_ticks;

  always #5 i_clk = ~i_clk;

  uart_alu_sequencer #(
    .DBIT          (DBIT),
    .OP_BITS       (OP_BITS),
    .TIMEOUT_TICKS (TT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_s_tick     (i_s_tick),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // External combinational ALU.
  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);
  assign got_vec = {o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun};

  function automatic logic [33:0] exp_vec();
    return {m_a, m_b, m_op, m_tx, m_start, m_busy, m_to, m_ov};
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
    m_start = 0; m_busy = 0; m_to = 0; m_ov = 0; m_exec = 0;
    m_n = 0; m_ticks = 0;
  endtask

  // One clock edge of the behavioural rules: bytes fill A, B, op in turn;
  // a full frame makes the sequencer busy until the transmitter is done.
  task automatic model_step(input bit rx, input logic [7:0] d, input bit tick, input bit txd);
    m_to = 0;
    m_ov = 0;
    if (m_busy) begin
      m_ov = rx;
      if (m_exec) begin
        m_tx = alu_ref(m_a, m_b, m_op);
        m_start = 1;
        m_exec = 0;
      end else begin
        m_start = 0;
        if (txd) m_busy = 0;
      end
    end else begin
      m_start = 0;
      if (rx) begin
        if (m_n == 0) m_a = d;
        else if (m_n == 1) m_b = d;
        else begin
          m_op = d[5:0];
          m_busy = 1;
          m_exec = 1;
        end
        m_n = (m_n + 1) % 3;
        m_ticks = 0;
      end else if (m_n != 0 && tick) begin
        m_ticks++;
        if (m_ticks == TT) begin
          m_to = 1;
          m_n = 0;
          m_ticks = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit rx, input logic [7:0] d, input bit tick, input bit txd);
    i_rx_done = rx;
    i_rx_data = d;
    i_s_tick  = tick;
    i_tx_done = txd;
    @(posedge i_clk);
    model_step(rx, d, tick, txd);
    #1;
    i_rx_done = 1'b0;
    i_s_tick  = 1'b0;
    i_tx_done = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (got_vec !== 34'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", got_vec);
    end
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
  endtask

  task automatic test_reset();
    i_rx_done = 0; i_rx_data = 0; i_s_tick = 0; i_tx_done = 0;
    do_reset();
    checks++;
    if (got_vec !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", got_vec);
    end
    cyc(0, 8'h00, 1, 1);
    checks++;
    if (got_vec !== 34'd0) begin
      errors++;
      $display("FAIL reset_idle got %h exp 0", got_vec);
    end
  endtask

  task automatic test_basic_add();
    cyc(1, 8'h05, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h20, 0, 0);
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_busy, o_tx_start} !== {8'h05, 8'h03, 6'h20, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_operands got a=%h b=%h op=%h busy=%b start=%b", o_alu_a, o_alu_b, o_alu_op, o_busy, o_tx_start);
    end
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin
      errors++;
      $display("FAIL add_start got start=%b tx=%h exp 1 08", o_tx_start, o_tx_data);
    end
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (o_tx_start !== 1'b0 || o_tx_data !== 8'h08 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL add_hold got start=%b tx=%h busy=%b exp 0 08 1", o_tx_start, o_tx_data, o_busy);
    end
    cyc(0, 8'h00, 0, 1);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL add_done got busy=%b exp 0", o_busy);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           output logic [7:0] tx);
    cyc(1, a, 0, 0);
    cyc(1, b, 0, 0);
    cyc(1, op, 0, 0);
    cyc(0, 8'h00, 0, 0);
    tx = o_tx_data;
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_sub_wrap();
    logic [7:0] tx;
    run_frame(8'h03, 8'h05, 8'h22, tx);
    checks++;
    if (tx !== 8'hFE) begin
      errors++;
      $display("FAIL sub_wrap got %h exp FE", tx);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL sub_idle got busy=%b exp 0", o_busy);
    end
    run_frame(8'hF0, 8'h0F, 8'h25, tx);
    checks++;
    if (tx !== 8'hFF) begin
      errors++;
      $display("FAIL or_frame got %h exp FF", tx);
    end
  endtask

  task automatic test_overrun();
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h20, 0, 0);
    cyc(1, 8'hAA, 0, 0);   // byte during EXEC
    checks++;
    if (o_overrun !== 1'b1 || o_tx_start !== 1'b1 || o_tx_data !== 8'h03) begin
      errors++;
      $display("FAIL ovr_exec got ov=%b start=%b tx=%h exp 1 1 03", o_overrun, o_tx_start, o_tx_data);
    end
    cyc(1, 8'hAA, 0, 0);   // byte during WAIT_TX
    checks++;
    if ({o_overrun, o_alu_a, o_alu_b, o_tx_data} !== {1'b1, 8'h01, 8'h02, 8'h03}) begin
      errors++;
      $display("FAIL ovr_wait got ov=%b a=%h b=%h tx=%h", o_overrun, o_alu_a, o_alu_b, o_tx_data);
    end
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_pulse got %b exp 0", o_overrun);
    end
    cyc(1, 8'hBB, 0, 1);   // coincident with tx_done
    checks++;
    if (o_overrun !== 1'b1 || o_busy !== 1'b0 || o_alu_a !== 8'h01) begin
      errors++;
      $display("FAIL ovr_txdone got ov=%b busy=%b a=%h exp 1 0 01", o_overrun, o_busy, o_alu_a);
    end
    cyc(1, 8'h10, 0, 0);   // back-to-back: accepted as A
    checks++;
    if (o_alu_a !== 8'h10 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got a=%h ov=%b exp 10 0", o_alu_a, o_overrun);
    end
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (o_tx_data !== 8'h08) begin
      errors++;
      $display("FAIL sra_frame got %h exp 08", o_tx_data);
    end
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_timeout();
    int early;
    cyc(1, 8'h11, 0, 0);
    early = 0;
    for (int i = 0; i < TT - 1; i++) begin
      cyc(0, 8'h00, 1, 0);
      if (o_timeout !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_early got %0d pulses exp 0", early);
    end
    cyc(0, 8'h00, 1, 0);
    checks++;
    if (o_timeout !== 1'b1 || o_alu_a !== 8'h11) begin
      errors++;
      $display("FAIL to_fire got to=%b a=%h exp 1 11", o_timeout, o_alu_a);
    end
    cyc(0, 8'h00, 1, 0);
    checks++;
    if (o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse got %b exp 0", o_timeout);
    end
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h20, 0, 0);
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_busy} !== {8'h01, 8'h02, 6'h20, 1'b1}) begin
      errors++;
      $display("FAIL to_fresh got a=%h b=%h op=%h busy=%b", o_alu_a, o_alu_b, o_alu_op, o_busy);
    end
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);
    // Byte arriving on the expiring tick is accepted.
    cyc(1, 8'h11, 0, 0);
    for (int i = 0; i < TT - 1; i++) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h22, 1, 0);
    checks++;
    if (o_timeout !== 1'b0 || o_alu_b !== 8'h22) begin
      errors++;
      $display("FAIL to_race got to=%b b=%h exp 0 22", o_timeout, o_alu_b);
    end
    for (int i = 0; i < TT - 1; i++) cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h26, 0, 0);
    cyc(0, 8'h00, 0, 0);
    checks++;
    if (o_tx_data !== 8'h33 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_xor got tx=%h to=%b exp 33 0", o_tx_data, o_timeout);
    end
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] tx;
    cyc(1, 8'h09, 0, 0);
    cyc(1, 8'h0A, 0, 0);
    do_reset();
    checks++;
    if (got_vec !== 34'd0) begin
      errors++;
      $display("FAIL rst_mid got %h exp 0", got_vec);
    end
    run_frame(8'h07, 8'h01, 8'h02, tx);
    checks++;
    if (tx !== 8'h03) begin
      errors++;
      $display("FAIL rst_srl got %h exp 03", tx);
    end
  endtask

  task automatic test_stray_tx_done();
    cyc(0, 8'h00, 0, 1);   // WAIT_A
    checks++;
    if (got_vec !== exp_vec() || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_a got %h exp %h", got_vec, exp_vec());
    end
    cyc(1, 8'h44, 0, 0);
    cyc(0, 8'h00, 0, 1);   // WAIT_B
    checks++;
    if (got_vec !== exp_vec() || o_alu_a !== 8'h44) begin
      errors++;
      $display("FAIL stray_b got %h exp %h", got_vec, exp_vec());
    end
    cyc(1, 8'h04, 0, 0);
    cyc(1, 8'h20, 0, 0);
    cyc(0, 8'h00, 0, 0);   // start pulse, then reset mid-transmit
    do_reset();
    cyc(0, 8'h00, 0, 1);   // transmitter finishing an untracked frame
    checks++;
    if (got_vec !== 34'd0) begin
      errors++;
      $display("FAIL stray_after_rst got %h exp 0", got_vec);
    end
    cyc(1, 8'h5A, 0, 0);
    checks++;
    if (o_alu_a !== 8'h5A || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_accept got a=%h busy=%b exp 5A 0", o_alu_a, o_busy);
    end
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h24, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0));
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random cyc %0d got %h exp %h", i, got_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_add();
    test_sub_wrap();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    test_stray_tx_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Control block between the UART receiver and transmitter in the UART/ALU top level. Collects three received bytes in order (operand A, operand B, opcode) and presents them to the external combinational ALU. Registers the ALU result and hands it to the transmitter with a one-cycle start pulse. Recovers from stalled frames with a tick-based timeout and flags bytes that arrive while busy.

## Interface
Parameters:
- DBIT, 8, data/operand width
- OP_BITS, 6, opcode width; taken from the low OP_BITS bits of the third byte
- TIMEOUT_TICKS, 16384, baud ticks allowed between bytes within one frame

Ports:
- i_clk  in  1  system clock, single clock domain
- i_reset  in  1  asynchronous, active-low reset
- i_s_tick  in  1  baud-rate tick, one i_clk cycle wide
- i_rx_done  in  1  receiver byte-valid pulse
- i_rx_data  in  DBIT  received byte, valid while i_rx_done is high
- i_tx_done  in  1  transmitter frame-complete pulse
- i_alu_result  in  DBIT  combinational ALU result
- o_alu_a  out  DBIT  registered operand A
- o_alu_b  out  DBIT  registered operand B
- o_alu_op  out  OP_BITS  registered opcode
- o_tx_data  out  DBIT  byte to transmit, stable from the o_tx_start pulse until i_tx_done
- o_tx_start  out  1  transmit request, one-cycle pulse
- o_busy  out  1  high in EXEC and WAIT_TX
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded
- o_overrun  out  1  one-cycle pulse when a received byte is dropped

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A: on i_rx_done, load o_alu_a from i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_done, load o_alu_b and go to WAIT_OP.
- WAIT_OP: on i_rx_done, load o_alu_op from i_rx_data[OP_BITS-1:0] and go to EXEC.
- EXEC, one cycle: load o_tx_data from i_alu_result, set o_tx_start to 1, go to WAIT_TX.
- WAIT_TX: o_tx_start returns to 0. On i_tx_done, go to WAIT_A.
- Busy drop: an i_rx_done in EXEC or WAIT_TX drops the byte and pulses o_overrun. This includes an i_rx_done in the same cycle as i_tx_done.
- Timeout counter, width $clog2(TIMEOUT_TICKS+1):
  - Cleared on every accepted byte and in every state other than WAIT_B and WAIT_OP.
  - In WAIT_B and WAIT_OP, increments on each i_s_tick.
  - When the counter reaches TIMEOUT_TICKS: go to WAIT_A, pulse o_timeout, clear the counter. Operand registers keep their values.
- i_rx_done and timeout expiry in the same cycle: the byte is accepted and the counter is cleared; no timeout.
- Reset, including mid-frame or mid-transmit:
  - State goes to WAIT_A and the counter clears.
  - All outputs go to 0: o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun.
  - A transmitter frame already in progress is not tracked; a later i_tx_done in WAIT_A is ignored.
- i_tx_done outside WAIT_TX is ignored.

## Timing
- All outputs are registered.
- Bytes are accepted on the clock edge where i_rx_done is sampled high.
- Third i_rx_done sampled at edge N:
  - o_alu_op is valid after edge N.
  - o_tx_data is valid and o_tx_start is high after edge N+1.
  - o_tx_start is low after edge N+2.
- ALU path budget: i_alu_result must settle within one clock after o_alu_op changes.
- o_busy rises after edge N and falls on the edge where i_tx_done is sampled.
- Back-to-back frames are allowed: a byte on the cycle immediately after leaving WAIT_TX is accepted as A.

## Structure
- Shared package uart_seq_pkg holds the state encoding localparams (3-bit) and the ALU opcode constants used by the bench: ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02.
- One natural sub-module: tick_timeout, the counter with clear, enable and expiry; parameterised on TIMEOUT_TICKS.
- Integration: instantiated in the top between RX_Uart and TX_Uart, replacing the direct data_line_itot and tx_start wiring.

## Test plan
- Basic add: bytes 0x05, 0x03, 0x20 with a bench ALU model -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08; o_tx_start high exactly one cycle, at N+1.
- Sub wrap: 0x03, 0x05, 0x22 -> o_tx_data=0xFE. Then i_tx_done -> o_busy=0, state WAIT_A; next frame 0xF0, 0x0F, 0x25 -> 0xFF.
- Overrun: extra byte 0xAA during WAIT_TX -> o_overrun pulses once, operands unchanged, o_tx_data holds. An i_rx_done coincident with i_tx_done is also dropped.
- Timeout: TIMEOUT_TICKS=8, byte 0x11 then 8 ticks with no byte -> o_timeout pulse, state WAIT_A. Next three bytes form a fresh frame. A byte on the 8th-tick cycle is accepted with no timeout.
- Reset mid-frame: two bytes received, then i_reset low for 2 cycles -> all outputs 0. Subsequent bytes 0x07, 0x01, 0x02 (SRL) -> o_tx_data=0x03.
- Stray i_tx_done in WAIT_A or WAIT_B -> no state change, no output change.
